// File: rtl/seq_pkg.sv
// Shared definitions for the converter start-up / hand-over / shutdown sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOFTSTART = 3'd1,
    HANDOVER  = 3'd2,
    RUN       = 3'd3,
    STOP      = 3'd4,
    FAULT     = 3'd5
  } seq_state_t;

  // Bit positions inside the latched fault code
  localparam int FLT_ADA = 0;
  localparam int FLT_ADB = 1;
  localparam int FLT_HO  = 2;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // States in which the bridge switches and the ADC flags are monitored
  function automatic logic is_active(input seq_state_t s);
    return (s == SOFTSTART) || (s == HANDOVER) || (s == RUN);
  endfunction

endpackage

// File: rtl/ol_carrier.sv
// Open-loop carrier: square wave with a half-period of CLK_DIV_OL clocks.
// restart forces counter 0 and carrier high on the next edge. carrier_next
// is the value the carrier will take after the coming edge, so the owner can
// register it into its own output flop without adding a clock of latency.
module ol_carrier #(
  parameter int CLK_DIV_OL = 1000
) (
  input  logic clk,
  input  logic restart,
  output logic carrier,
  output logic carrier_next,
  output logic period_done
);

  localparam int CW = $clog2(CLK_DIV_OL) + 1;

  logic [CW-1:0] cnt_reg;
  logic          carrier_reg;
  logic          wrap;

  assign wrap         = (cnt_reg >= CW'(CLK_DIV_OL - 1));
  assign carrier      = carrier_reg;
  assign carrier_next = restart ? 1'b1 : (carrier_reg ^ wrap);
  // A low-to-high toggle completes one full carrier period
  assign period_done  = !restart && wrap && !carrier_reg;

  // Half-period counter with carrier toggle on wrap
  always_ff @(posedge clk) begin
    if (restart) begin
      cnt_reg     <= '0;
      carrier_reg <= 1'b1;
    end else begin
      carrier_reg <= carrier_reg ^ wrap;
      cnt_reg     <= wrap ? '0 : cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/converter_sequencer.sv
// Resonant converter sequencer: soft-start on an open-loop carrier, glitch-free
// hand-over to the closed-loop sigma, orderly stop, latched faults.
// Optional build macro SEQ_OR_FILTER_EN: ADC out-of-range flags must stay high
// for OR_FILTER consecutive clocks before they trip (otherwise one clock trips).
module converter_sequencer
  import seq_pkg::*;
#(
  parameter int CLK_DIV_OL        = 1000,
  parameter int SOFTSTART_PERIODS = 256,
  parameter int HANDOVER_TMO      = 4096,
  parameter int STOP_CYCLES       = 200,
  parameter int OR_FILTER         = 16
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic       i_sigma_cl,
  input  logic       i_ada_or,
  input  logic       i_adb_or,
  input  logic       i_fault_clear,
  output logic       o_sigma,
  output logic       o_gate_en,
  output logic [2:0] o_state,
  output logic       o_fault,
  output logic [2:0] o_fault_code
);

  localparam int MAXP = imax(imax(imax(SOFTSTART_PERIODS, HANDOVER_TMO),
                                  imax(STOP_CYCLES, OR_FILTER)), CLK_DIV_OL);
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // True when the counter is on its last clock before reaching limit
  function automatic logic at_last(input logic [CW-1:0] cnt, input int limit);
    return (int'(cnt) + 1) >= limit;
  endfunction

  seq_state_t    state_reg, state_next;
  logic [CW-1:0] period_cnt_reg, period_cnt_next;
  logic [CW-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic          sigma_reg, sigma_next;
  logic          gate_en_reg, gate_en_next;
  logic          fault_reg, fault_next;
  logic [2:0]    code_reg, code_next;
  logic          carrier, carrier_next, period_done, restart;
  logic          active, trip;
  logic [1:0]    or_flag, or_trip;

  // Carrier restarts whenever the bridge is not running open-loop
  assign restart = i_RESET || !((state_reg == SOFTSTART) || (state_reg == HANDOVER));
  assign active  = is_active(state_reg);
  assign or_flag = {i_adb_or, i_ada_or};
  assign trip    = |or_trip;

  ol_carrier #(.CLK_DIV_OL(CLK_DIV_OL)) u_carrier (
    .clk          (i_clock),
    .restart      (restart),
    .carrier      (carrier),
    .carrier_next (carrier_next),
    .period_done  (period_done)
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_or
`ifdef SEQ_OR_FILTER_EN
      logic [CW-1:0] run_reg;
      // Consecutive out-of-range clocks, only while monitored
      always_ff @(posedge i_clock) begin
        if (i_RESET || !active || !or_flag[gi]) run_reg <= '0;
        else if (run_reg != CNT_MAX)            run_reg <= run_reg + CW'(1);
      end
      assign or_trip[gi] = active && or_flag[gi] && at_last(run_reg, OR_FILTER);
`else
      assign or_trip[gi] = active && or_flag[gi];
`endif
    end
  endgenerate

  // Next state, counters and registered output values
  always_comb begin
    state_next      = state_reg;
    code_next       = code_reg;
    period_cnt_next = '0;
    dwell_cnt_next  = '0;
    gate_en_next    = 1'b0;
    sigma_next      = 1'b0;
    fault_next      = 1'b0;

    case (state_reg)
      IDLE:
        if (i_enable) state_next = SOFTSTART;
      SOFTSTART, HANDOVER, RUN: begin
        if (trip) begin
          state_next         = FAULT;
          code_next[FLT_ADA] = or_trip[FLT_ADA];
          code_next[FLT_ADB] = or_trip[FLT_ADB];
        end else if (!i_enable) begin
          state_next = STOP;
        end else if (state_reg == SOFTSTART) begin
          if (period_done && at_last(period_cnt_reg, SOFTSTART_PERIODS))
            state_next = HANDOVER;
        end else if (state_reg == HANDOVER) begin
          // Equal values make the switch-over invisible on o_sigma
          if (i_sigma_cl == carrier) begin
            state_next = RUN;
          end else if (at_last(dwell_cnt_reg, HANDOVER_TMO)) begin
            state_next        = FAULT;
            code_next[FLT_HO] = 1'b1;
          end
        end
      end
      STOP:
        if (at_last(dwell_cnt_reg, STOP_CYCLES)) state_next = IDLE;
      FAULT:
        if (i_fault_clear && !i_enable) begin
          state_next = IDLE;
          code_next  = '0;
        end
      default:
        state_next = IDLE;
    endcase

    if (state_reg == SOFTSTART)
      period_cnt_next = (period_done && period_cnt_reg != CNT_MAX)
                        ? period_cnt_reg + CW'(1) : period_cnt_reg;

    if (state_next == state_reg && dwell_cnt_reg != CNT_MAX)
      dwell_cnt_next = dwell_cnt_reg + CW'(1);
    else if (state_next == state_reg)
      dwell_cnt_next = dwell_cnt_reg;

    gate_en_next = is_active(state_next);
    fault_next   = (state_next == FAULT);
    case (state_next)
      SOFTSTART, HANDOVER: sigma_next = carrier_next;
      RUN:                 sigma_next = i_sigma_cl;
      default:             sigma_next = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state_reg      <= IDLE;
      period_cnt_reg <= '0;
      dwell_cnt_reg  <= '0;
      sigma_reg      <= 1'b0;
      gate_en_reg    <= 1'b0;
      fault_reg      <= 1'b0;
      code_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      period_cnt_reg <= period_cnt_next;
      dwell_cnt_reg  <= dwell_cnt_next;
      sigma_reg      <= sigma_next;
      gate_en_reg    <= gate_en_next;
      fault_reg      <= fault_next;
      code_reg       <= code_next;
    end
  end

  assign o_state      = state_reg;
  assign o_sigma      = sigma_reg;
  assign o_gate_en    = gate_en_reg;
  assign o_fault      = fault_reg;
  assign o_fault_code = code_reg;

endmodule

// File: tb/tb_converter_sequencer.sv
// Bench for converter_sequencer: cycle model from the behavioural rules plus
// directed literal expectations, followed by a randomized soak.
module tb_converter_sequencer;

  localparam int DIV    = 4;
  localparam int PER    = 3;
  localparam int HO_TMO = 16;
  localparam int STOPC  = 8;
  localparam int ORF    = 4;
  localparam int SS_LEN = 2 * DIV * PER;
`ifdef SEQ_OR_FILTER_EN
  localparam int FILT = ORF;
`else
  localparam int FILT = 1;
`endif

  logic clk = 1'b0;
  logic rst, en, sig_cl, ada, adb, clr;
  logic       o_sigma, o_gate_en, o_fault;
  logic [2:0] o_state, o_fault_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  converter_sequencer #(
    .CLK_DIV_OL(DIV), .SOFTSTART_PERIODS(PER), .HANDOVER_TMO(HO_TMO),
    .STOP_CYCLES(STOPC), .OR_FILTER(ORF)
  ) dut (
    .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_sigma_cl(sig_cl),
    .i_ada_or(ada), .i_adb_or(adb), .i_fault_clear(clr),
    .o_sigma(o_sigma), .o_gate_en(o_gate_en), .o_state(o_state),
    .o_fault(o_fault), .o_fault_code(o_fault_code)
  );

  // ---------------- behavioural model ----------------
  int         m_state, m_t, m_dwell, m_run_a, m_run_b;
  logic       m_sigma, m_gate, m_fault;
  logic [2:0] m_code;
  bit         m_valid = 0;

  // Open-loop carrier level t clocks after soft-start began
  function automatic logic car_at(input int t);
    return ((t / DIV) % 2) == 0;
  endfunction

  task automatic model_step();
    int nxt;
    bit act, ta, tb;
    m_valid = 1;
    if (rst) begin
      m_state = 0; m_t = 0; m_dwell = 0; m_run_a = 0; m_run_b = 0;
      m_sigma = 0; m_gate = 0; m_fault = 0; m_code = 0;
      return;
    end
    act = (m_state >= 1 && m_state <= 3);
    ta = act && ada && (m_run_a + 1 >= FILT);
    tb = act && adb && (m_run_b + 1 >= FILT);
    m_run_a = (act && ada) ? m_run_a + 1 : 0;
    m_run_b = (act && adb) ? m_run_b + 1 : 0;
    nxt = m_state;
    case (m_state)
      0: if (en) nxt = 1;
      1, 2, 3: begin
        if (ta || tb) begin
          nxt = 5; m_code = {1'b0, tb, ta};
        end else if (!en) nxt = 4;
        else if (m_state == 1 && m_t + 1 == SS_LEN) nxt = 2;
        else if (m_state == 2 && sig_cl == car_at(m_t)) nxt = 3;
        else if (m_state == 2 && m_dwell + 1 == HO_TMO) begin
          nxt = 5; m_code = 3'b100;
        end
      end
      4: if (m_dwell + 1 == STOPC) nxt = 0;
      5: if (clr && !en) begin nxt = 0; m_code = 0; end
      default: nxt = 0;
    endcase
    if (m_state == 0 && nxt == 1) m_t = 0; else m_t = m_t + 1;
    m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
    m_gate  = (nxt >= 1 && nxt <= 3);
    m_fault = (nxt == 5);
    m_sigma = (nxt == 1 || nxt == 2) ? car_at(m_t) : (nxt == 3) ? sig_cl : 1'b0;
    m_state = nxt;
  endtask

  always @(posedge clk) model_step();

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if ({o_state, o_gate_en, o_sigma, o_fault, o_fault_code} !==
          {3'(m_state), m_gate, m_sigma, m_fault, m_code}) begin
        n_err++;
        $display("FAIL model t=%0t: state/gate/sigma/fault/code got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
                 $time, o_state, o_gate_en, o_sigma, o_fault, o_fault_code,
                 m_state, m_gate, m_sigma, m_fault, m_code);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (o_state !== s && n < budget) begin tick(); n++; end
    check("wait_state", 32'(o_state), 32'(s));
  endtask

  task automatic go_run();
    en = 0; ada = 0; adb = 0; sig_cl = 0;
    tick(); clr = 1; tick(); clr = 0;
    wait_state(3'd0, 40);
    en = 1;
    wait_state(3'd3, 100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pat;
    logic        prev;
    int          ho, n;

    rst = 1; en = 0; sig_cl = 0; ada = 0; adb = 0; clr = 0;
    repeat (3) tick();
    check("reset_state", 32'(o_state), 0);
    check("reset_outs", {o_gate_en, o_sigma, o_fault, o_fault_code}, 0);
    rst = 0;
    tick();

    // Nominal start: 4 high / 4 low three times, then hand-over
    en = 1; sig_cl = 0;
    tick();
    check("ss_entry", {29'd0, o_state}, 1);
    check("ss_gate", 32'(o_gate_en), 1);
    pat = 24'hF0F0F0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) tick();
      check("ss_sigma", 32'(o_sigma), 32'(pat[23-k]));
    end
    tick();
    check("ho_at_24", 32'(o_state), 2);
    tick(); tick(); tick(); tick();
    check("ho_carrier_low", {o_state, o_sigma}, {3'd2, 1'b0});
    tick();
    check("run_entry", {o_state, o_sigma}, {3'd3, 1'b0});

    // RUN tracking with one clock lag
    for (int i = 0; i < 20; i++) begin
      sig_cl = 1'($urandom_range(0, 1));
      prev = sig_cl;
      tick();
      check("run_track", 32'(o_sigma), 32'(prev));
    end

    // Stop sequence
    en = 0;
    tick();
    check("stop_gate", {o_state, o_gate_en, o_sigma}, {3'd4, 1'b0, 1'b0});
    for (int i = 1; i < STOPC; i++) begin
      tick();
      check("stop_hold", 32'(o_state), 4);
    end
    tick();
    check("stop_done", 32'(o_state), 0);

    // Hand-over timeout: keep sigma_cl opposite to the carrier
    en = 1; sig_cl = 0; ho = 0; n = 0;
    while (o_state !== 3'd5 && n < 200) begin
      tick();
      sig_cl = ~o_sigma;
      if (o_state == 3'd2) ho++;
      n++;
    end
    check("ho_tmo_state", 32'(o_state), 5);
    check("ho_tmo_len", ho, HO_TMO);
    check("ho_tmo_code", 32'(o_fault_code), 3'b100);

    // Clear ignored while enable is held, accepted once it is low
    clr = 1; tick(); clr = 0;
    check("clr_ignored", {o_state, o_fault, o_fault_code}, {3'd5, 1'b1, 3'b100});
    en = 0; clr = 1; tick(); clr = 0;
    check("clr_ok", {o_state, o_fault, o_fault_code}, {3'd0, 1'b0, 3'b000});

    // Short ADA burst (trips only when unfiltered)
    go_run();
    ada = 1; repeat (3) tick(); ada = 0; tick();
    check("ada_burst3", 32'(o_state), (FILT > 3) ? 3 : 5);

    go_run();
    ada = 1;
    repeat (FILT - 1) tick();
    check("ada_pre_trip", 32'(o_state), 3);
    tick();
    check("ada_trip", {o_state, o_gate_en, o_fault_code}, {3'd5, 1'b0, 3'b001});
    ada = 0;

    go_run();
    ada = 1; adb = 1;
    repeat (FILT) tick();
    check("both_trip", {o_state, o_fault_code}, {3'd5, 3'b011});
    ada = 0; adb = 0;

    // Reset inside SOFTSTART
    en = 0; tick(); clr = 1; tick(); clr = 0;
    en = 1; repeat (6) tick();
    check("pre_rst_ss", 32'(o_state), 1);
    rst = 1; tick();
    check("rst_in_ss", {o_state, o_gate_en, o_sigma, o_fault, o_fault_code}, 0);
    rst = 0;

    // Reset inside FAULT
    wait_state(3'd3, 100);
    adb = 1;
    wait_state(3'd5, 20);
    rst = 1; tick();
    check("rst_in_fault", {o_state, o_gate_en, o_sigma, o_fault, o_fault_code}, 0);
    rst = 0; adb = 0; en = 0;
    tick();

    // Randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      sig_cl = 1'($urandom_range(0, 1));
      ada = ($urandom_range(0, 99) < 6) ? 1'b1 : (ada && $urandom_range(0, 3) != 0);
      adb = ($urandom_range(0, 99) < 4) ? 1'b1 : (adb && $urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if (o_state == 3'd5 && $urandom_range(0, 9) == 0) en = 0;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/converter_sequencer.md
# converter_sequencer

Start-up, hand-over and shutdown sequencer for the resonant converter power stage. It runs the bridge open-loop at a fixed carrier frequency for a soft-start interval. It then hands switching authority to the hybrid control law's sigma at a glitch-free instant. It trips and latches a fault on persistent ADC out-of-range or failed hand-over. Its outputs feed the two dead-time generators (sigma and ~sigma) and gate the bridge enable.

## Interface
- CLK_DIV_OL, 1000: open-loop carrier half-period in clocks (1000 at 100 MHz gives 50 kHz).
- SOFTSTART_PERIODS, 256: full carrier periods spent in soft-start.
- HANDOVER_TMO, 4096: maximum clocks allowed in HANDOVER.
- STOP_CYCLES, 200: clocks with gates off before returning to IDLE.
- OR_FILTER, 16: consecutive out-of-range clocks needed to trip (used only with SEQ_OR_FILTER_EN).
- i_clock  in  1  system clock (100 MHz domain); single clock.
- i_RESET  in  1  synchronous, active-high reset.
- i_enable  in  1  run request (level).
- i_sigma_cl  in  1  closed-loop switching variable from the hybrid control.
- i_ada_or, i_adb_or  in  1 each  ADC out-of-range flags, already synchronised to i_clock.
- i_fault_clear  in  1  single-cycle fault acknowledge pulse.
- o_sigma  out  1  switching variable to the dead-time stages.
- o_gate_en  out  1  bridge gate enable (ANDed with the Q outputs at top level).
- o_state  out  3  current state encoding.
- o_fault  out  1  fault latched.
- o_fault_code  out  3  bit0 ADA OR, bit1 ADB OR, bit2 hand-over timeout.

## Operation
- States (o_state): IDLE=0, SOFTSTART=1, HANDOVER=2, RUN=3, STOP=4, FAULT=5.
- IDLE: o_gate_en=0, o_sigma=0. If i_enable=1, go to SOFTSTART. On entry the carrier counter is 0 and carrier=1.
- Carrier (in ol_carrier): the counter counts 0..CLK_DIV_OL-1, then wraps and toggles the carrier. The period counter increments on each carrier 0→1 toggle.
- SOFTSTART: o_gate_en=1, o_sigma=carrier. When the period count reaches SOFTSTART_PERIODS, go to HANDOVER.
- HANDOVER: o_sigma=carrier, and the carrier keeps running.
  - On the first clock where i_sigma_cl==carrier, go to RUN.
  - If HANDOVER_TMO clocks elapse first, go to FAULT with bit2 set.
- RUN: o_sigma=i_sigma_cl, registered.
- In SOFTSTART, HANDOVER or RUN, i_enable=0 sends the block to STOP.
- STOP: o_gate_en=0 and o_sigma=0 immediately. Count STOP_CYCLES clocks, then go to IDLE. i_enable is ignored until the block is back in IDLE.
- Out-of-range monitoring is active only in SOFTSTART, HANDOVER and RUN.
  - A trip goes to FAULT and sets bit0 and/or bit1 for whichever flags tripped in the same clock.
  - Trip has priority over i_enable=0 and over the hand-over transition in the same clock.
- FAULT: o_gate_en=0, o_sigma=0, o_fault=1, o_fault_code held.
  - i_fault_clear with i_enable=0 clears the code and goes to IDLE.
  - i_fault_clear with i_enable=1 is ignored, so a run request still asserted cannot restart the stage.
- Counters are unsigned. Width is $clog2 of the largest parameter + 1. They saturate and never wrap.

## Timing
- All outputs are registered. Reset values: o_state=IDLE, o_gate_en=0, o_sigma=0, o_fault=0, o_fault_code=0.
- i_enable rising in IDLE: o_state=1 and o_gate_en=1 one clock later. o_sigma=1 on that same clock.
- Soft-start length is exactly 2·CLK_DIV_OL·SOFTSTART_PERIODS clocks.
- RUN: o_sigma follows i_sigma_cl with 1-clock latency.
- At the hand-over clock o_sigma does not toggle, because the values are equal by construction.
- Trip to o_gate_en=0 takes 1 clock after the qualifying sample.
- i_RESET mid-operation forces reset values on the next edge, including inside FAULT. Reset clears the latched fault.

## Configuration
- SEQ_OR_FILTER_EN defined: each OR flag needs OR_FILTER consecutive high clocks to trip. Its run counter resets on any low clock and on leaving the monitored states.
- SEQ_OR_FILTER_EN undefined: a single high clock trips. OR_FILTER is unused.

## Structure
- Shared package seq_pkg:
  - state enum constants (IDLE..FAULT);
  - fault bit indices FLT_ADA=0, FLT_ADB=1, FLT_HO=2.
- Sub-module ol_carrier:
  - inputs: clock, sync restart, CLK_DIV_OL parameter;
  - outputs: carrier, period-complete strobe.
- The top state machine, filters and counters live in converter_sequencer.

## Test plan
Bench parameters: CLK_DIV_OL=4, SOFTSTART_PERIODS=3, HANDOVER_TMO=16, STOP_CYCLES=8, OR_FILTER=4.
- Nominal start, i_sigma_cl=0, i_enable=1 from idle → o_sigma toggles 4 high / 4 low three times; o_state=2 after 24 clocks; RUN on the first carrier-low clock; o_sigma then tracks i_sigma_cl with 1-clock lag.
- i_sigma_cl held at the opposite of the carrier → o_state=5 and o_fault_code=3'b100 after 16 clocks in HANDOVER.
- In RUN, drop i_enable → o_gate_en=0 next clock; o_state=4 for 8 clocks, then 0.
- In RUN, i_ada_or high for 3 clocks then low → no trip (filter on). High for 4 clocks → FAULT, code 3'b001. Both flags 4 clocks together → code 3'b011.
- In FAULT, i_fault_clear with i_enable=1 → stays in FAULT. Clear with i_enable=0 → IDLE, code 0.
- i_RESET asserted in SOFTSTART and in FAULT → all outputs at reset values on the next clock.
